// File: rtl/vga_timing_pkg.sv
// Shared types and default timing for the VGA frame/line sequencer (VESA 1600x900 reduced blanking).
package vga_timing_pkg;

    localparam int unsigned CNT_W = 11;

    localparam int unsigned H_RES_DEF   = 1600;
    localparam int unsigned H_FP_DEF    = 24;
    localparam int unsigned H_SYNC_DEF  = 80;
    localparam int unsigned H_BP_DEF    = 96;
    localparam int unsigned V_RES_DEF   = 900;
    localparam int unsigned V_FP_DEF    = 1;
    localparam int unsigned V_SYNC_DEF  = 3;
    localparam int unsigned V_BP_DEF    = 96;
    localparam int unsigned PIPE_DLY_MAX = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } tstate_t;

    // Raw or delayed video strobes travelling together through the delay line.
    typedef struct packed {
        logic dv;
        logic hs;
        logic vs;
    } strobe_t;

    localparam int unsigned STROBE_W = $bits(strobe_t);

    // Inclusive window test on an unsigned counter value.
    function automatic logic in_range(input logic [CNT_W-1:0] x,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with synchronous reset; DEPTH=0 degenerates to a wire.
module sync_delay_line #(
    parameter int unsigned   W       = 3,
    parameter int unsigned   DEPTH   = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        assign dout = din;
    end else begin : g_pipe
        logic [W-1:0] stage [DEPTH];

        // Shifts every clock regardless of sequencer state so a stopped frame drains out.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage[i] <= RST_VAL;
                end
            end else begin
                stage[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Frame/line sequencer: h/v counters, raw dv/hs/vs strobes, delayed strobe copies,
// and a start/stop handshake that only stops on frame boundaries.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned HRES     = H_RES_DEF,
    parameter int unsigned HFP      = H_FP_DEF,
    parameter int unsigned HSYNC    = H_SYNC_DEF,
    parameter int unsigned HBP      = H_BP_DEF,
    parameter int unsigned VRES     = V_RES_DEF,
    parameter int unsigned VFP      = V_FP_DEF,
    parameter int unsigned VSYNC    = V_SYNC_DEF,
    parameter int unsigned VBP      = V_BP_DEF,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned PIPE_DLY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             vga_dv_o,
    output logic             vga_hs_o,
    output logic             vga_vs_o,
    output logic             dly_dv_o,
    output logic             dly_hs_o,
    output logic             dly_vs_o,
    output logic             frame_start,
    output logic             frame_done,
    output logic             running
);

    localparam int unsigned HTOTAL = HRES + HFP + HSYNC + HBP;
    localparam int unsigned VTOTAL = VRES + VFP + VSYNC + VBP;

    if ((HTOTAL > 2048) || (VTOTAL > 2048)) begin : g_bad_total
        $error("vga_timing_ctrl: HTOTAL/VTOTAL must not exceed 2048");
    end
    if (PIPE_DLY > PIPE_DLY_MAX) begin : g_bad_dly
        $error("vga_timing_ctrl: PIPE_DLY must be in 0..15");
    end

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(HRES);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(VRES);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(HRES + HFP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(HRES + HFP + HSYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(VRES + VFP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(VRES + VFP + VSYNC - 1);

    localparam strobe_t STROBE_RST = '{dv: 1'b0, hs: ~HS_POL, vs: ~VS_POL};

    tstate_t          state;
    tstate_t          state_n;
    logic [CNT_W-1:0] h_n;
    logic [CNT_W-1:0] v_n;
    logic [CNT_W-1:0] h_inc;
    logic [CNT_W-1:0] v_inc;
    logic             h_wrap;
    logic             at_end;
    logic             act_n;
    logic             dv_n;
    logic             hs_n;
    logic             vs_n;
    logic             fs_n;
    logic             fd_n;
    strobe_t          raw_strobe;
    strobe_t          dly_strobe;

    // Next-state and next-output decode; every output register is loaded from here.
    always_comb begin
        state_n = state;
        h_n     = '0;
        v_n     = '0;
        act_n   = 1'b0;
        fs_n    = 1'b0;
        fd_n    = 1'b0;
        dv_n    = 1'b0;
        hs_n    = ~HS_POL;
        vs_n    = ~VS_POL;

        h_wrap = (h_cnt == H_LAST);
        at_end = h_wrap && (v_cnt == V_LAST);
        h_inc  = h_wrap ? '0 : h_cnt + CNT_W'(1);
        if (!h_wrap) begin
            v_inc = v_cnt;
        end else if (v_cnt == V_LAST) begin
            v_inc = '0;
        end else begin
            v_inc = v_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (en) begin
                    state_n = RUN;
                    act_n   = 1'b1;
                    fs_n    = 1'b1;
                end
            end
            RUN, STOPPING: begin
                // A pending stop only takes effect once the last pixel of the frame is out.
                if ((state == STOPPING) && !en && at_end) begin
                    state_n = IDLE;
                    fd_n    = 1'b1;
                end else begin
                    state_n = en ? RUN : STOPPING;
                    h_n     = h_inc;
                    v_n     = v_inc;
                    act_n   = 1'b1;
                    fs_n    = at_end;
                    fd_n    = at_end;
                end
            end
            default: state_n = IDLE;
        endcase

        if (act_n) begin
            dv_n = (h_n < H_ACT) && (v_n < V_ACT);
            hs_n = in_range(h_n, H_SYNC_BEG, H_SYNC_END) ? HS_POL : ~HS_POL;
            vs_n = in_range(v_n, V_SYNC_BEG, V_SYNC_END) ? VS_POL : ~VS_POL;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            vga_dv_o    <= 1'b0;
            vga_hs_o    <= ~HS_POL;
            vga_vs_o    <= ~VS_POL;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_n;
            h_cnt       <= h_n;
            v_cnt       <= v_n;
            vga_dv_o    <= dv_n;
            vga_hs_o    <= hs_n;
            vga_vs_o    <= vs_n;
            frame_start <= fs_n;
            frame_done  <= fd_n;
            running     <= (state_n != IDLE);
        end
    end

    assign raw_strobe = '{dv: vga_dv_o, hs: vga_hs_o, vs: vga_vs_o};

    sync_delay_line #(
        .W       (STROBE_W),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (STROBE_RST)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (raw_strobe),
        .dout (dly_strobe)
    );

    assign dly_dv_o = dly_strobe.dv;
    assign dly_hs_o = dly_strobe.hs;
    assign dly_vs_o = dly_strobe.vs;

endmodule
